// File: rtl/sc_stream_scheduler_if.sv
// Bundle of the scheduler's requester, shared-counter and bitstream signals.
// The master side feeds requests and the counter value; the slave side is the scheduler.
interface sc_stream_scheduler_if #(
  parameter int N    = 10,
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] value;
  logic              abort;
  logic [N-1:0]      cnt_value;
  logic              cnt_enable;
  logic              cnt_restart;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   owner;
  logic              busy;
  logic              bit_out;
  logic              bit_valid;
  logic              done;

  modport master (
    output req, value, abort, cnt_value,
    input  cnt_enable, cnt_restart, grant, owner, busy, bit_out, bit_valid, done
  );

  modport slave (
    input  req, value, abort, cnt_value,
    output cnt_enable, cnt_restart, grant, owner, busy, bit_out, bit_valid, done
  );
endinterface

// File: rtl/sc_stream_scheduler.sv
// Round-robin owner of one shared up-counter: each grant runs a full BOUND+1 cycle
// epoch and emits bit = (count < latched operand) every RUN cycle.
module sc_stream_scheduler #(
  parameter int N     = 10,
  parameter int BOUND = 1000,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sc_stream_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [ID_W-1:0] ptr, ptr_d;
  logic [ID_W-1:0] owner, owner_d;
  logic [NREQ-1:0] grant, grant_d;
  logic [N-1:0]    run_cnt, run_cnt_d;
  logic [N-1:0]    val_q;
  logic [ID_W:0]   pick;
  logic            take;

  // Returns {found, index}: first asserted request at or above p, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [ID_W-1:0] p);
    logic [2*NREQ-1:0] rot;
    logic [ID_W:0]     res;
    int                s;
    rot = {r, r} >> p;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        res = {1'b1, ID_W'(s)};
      end
    end
    return res;
  endfunction

  assign pick = rr_pick(bus.req, ptr);

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    owner_d   = owner;
    grant_d   = grant;
    run_cnt_d = run_cnt;
    take      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (pick[ID_W]) begin
          take    = 1'b1;
          state_d = LOAD;
          grant_d = NREQ'(1) << pick[ID_W-1:0];
          owner_d = pick[ID_W-1:0];
          ptr_d   = (pick[ID_W-1:0] == ID_W'(NREQ - 1)) ? '0 : pick[ID_W-1:0] + 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end else begin
          run_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Abort outranks completion on the final RUN cycle.
        if (bus.abort) begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end else begin
          run_cnt_d = run_cnt + 1'b1;
          if (run_cnt == N'(BOUND)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      grant   <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      grant   <= grant_d;
      run_cnt <= run_cnt_d;
    end
  end

  // Operand is pure data: latched on grant, never needs a reset value.
  always_ff @(posedge clk) begin
    if (take) val_q <= bus.value[pick[ID_W-1:0]*N +: N];
  end

  assign bus.grant       = grant;
  assign bus.owner       = owner;
  assign bus.busy        = (state != IDLE);
  assign bus.cnt_restart = (state == IDLE) || (state == LOAD);
  assign bus.cnt_enable  = (state == RUN) && !bus.abort;
  assign bus.bit_valid   = (state == RUN);
  assign bus.bit_out     = (state == RUN) && (bus.cnt_value < val_q);
  assign bus.done        = (state == DONE);

endmodule
